// File: rtl/piso_tx_scheduler.sv
// Two-requester frame scheduler driving an external PISO: it arbitrates, loads, shifts and spaces frames.
// Requests are accepted only in IDLE, and pause stalls shifting or blocks new grants.
module piso_tx_scheduler #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  input  logic [2*WIDTH-1:0] req_data,
  output logic [1:0]         req_ready,
  input  logic               pause,
  output logic               piso_load,
  output logic               piso_enable,
  output logic [WIDTH-1:0]   piso_data,
  output logic               busy,
  output logic               grant_id,
  output logic               tx_done,
  output logic [15:0]        frame_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             tx_done_q, tx_done_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             sel;

  // With both requesters valid the pointer decides; otherwise whichever one is valid.
  assign sel = (req_valid == 2'b11) ? ptr_q : req_valid[1];

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    tx_done_d     = 1'b0;
    frame_count_d = frame_count_q;
    req_ready     = 2'b00;
    piso_load     = 1'b0;
    piso_enable   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!reset && !pause && (req_valid != 2'b00)) begin
          req_ready[sel] = 1'b1;
          data_d         = sel ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
          grant_d        = sel;
          ptr_d          = ~sel;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        piso_load   = 1'b1;
        piso_enable = 1'b1;
        bit_cnt_d   = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (!pause) begin
          piso_enable = 1'b1;
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            tx_done_d     = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            bit_cnt_d     = '0;
            gap_cnt_d     = '0;
            state_d       = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      data_q        <= '0;
      grant_q       <= 1'b0;
      ptr_q         <= 1'b0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      tx_done_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      tx_done_q     <= tx_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign piso_data   = data_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign tx_done     = tx_done_q;
  assign frame_count = frame_count_q;

endmodule
